psi_index_extract: RTL

- Downstream consumer of the PSI intersection bit-vector. The upstream AND-reduction stage produces a b-bit membership vector: bit i set means element i is in every party's set.
- This block captures that vector on start and scans it W bits per cycle.
- It streams out the index of every set bit in ascending order over a valid/ready handshake, then reports the intersection cardinality.
- It turns the flat vector into a compact element list for the output/reveal stage.

---
 rtl/psi_pkg.sv | 10 +
 rtl/psi_lsb_encoder.sv | 22 ++
 rtl/psi_index_extract.sv | 89 ++++++++
 3 files changed

// File: rtl/psi_pkg.sv
// psi_pkg: shared FSM state type and index-width helper for the PSI index extractor.
package psi_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psi_lsb_encoder.sv
// psi_lsb_encoder: lowest-set-bit finder for one scan window.
// Ports: win (W-bit window) -> found (any bit set), pos (index of lowest set bit, 0 when none).
module psi_lsb_encoder
   import psi_pkg::*;
#(
   parameter int W  = 8,
   parameter int PW = idx_w(W)
) (
   input  logic [W-1:0]  win,
   output logic          found,
   output logic [PW-1:0] pos
);

   always_comb begin
      found = |win;
      pos   = '0;
      // scanning downward leaves the lowest set bit as the final assignment
      for (int i = W - 1; i >= 0; i--)
         if (win[i]) pos = PW'(i);
   end

endmodule

// File: rtl/psi_index_extract.sv
// psi_index_extract: captures the PSI membership vector on start and streams the index of
// every set bit in ascending order over valid/ready, then pulses done with the cardinality.
// Ports: clk, rst (async, active-low), start/in_vec (capture request in IDLE),
//        out_valid/out_ready/out_index (index stream), busy, done (1-cycle pulse),
//        count (indices accepted in the current or last scan).
module psi_index_extract
   import psi_pkg::*;
#(
   parameter  int B  = 256,
   parameter  int W  = 8,
   localparam int IW = idx_w(B),
   localparam int PW = idx_w(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [B-1:0]  in_vec,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_index,
   output logic          done,
   output logic [IW:0]   count
);

   localparam logic [IW-1:0] LAST_BASE = IW'(B - W);
   localparam logic [IW-1:0] STEP      = IW'(W);

   state_t        state_q, state_d;
   logic [B-1:0]  vec_q, vec_d;
   logic [IW-1:0] base_q, base_d;
   logic [IW:0]   count_q, count_d;
   logic          found;
   logic [PW-1:0] pos;

   psi_lsb_encoder #(.W(W), .PW(PW)) u_enc (
      .win   (vec_q[base_q +: W]),
      .found (found),
      .pos   (pos)
   );

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == SCAN) && found;
   assign done      = (state_q == DONE);
   assign out_index = out_valid ? base_q + IW'(pos) : '0;
   assign count     = count_q;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      base_d  = base_q;
      count_d = count_q;
      case (state_q)
         IDLE: if (start) begin
            vec_d   = in_vec;
            base_d  = '0;
            count_d = '0;
            state_d = SCAN;
         end
         SCAN: if (found) begin
            // accepted bits are cleared so the window drains to zero before base advances
            if (out_ready) begin
               vec_d[out_index] = 1'b0;
               count_d          = count_q + 1'b1;
            end
         end else if (base_q == LAST_BASE) begin
            state_d = DONE;
         end else begin
            base_d = base_q + STEP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         base_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         base_q  <= base_d;
         count_q <= count_d;
      end
   end

endmodule
